// File: rtl/tl_np_tag_mgr.sv
// Transaction tag pool for outbound non-posted requests.
// Hands out the lowest free tag to the request builder, frees tags on the
// final completion or on timeout, and flags completions that match no
// outstanding request.
module tl_np_tag_mgr #(
  parameter int NUM_TAGS  = 32,
  parameter int TAG_W     = 8,
  parameter int TICK_CYC  = 1024,
  parameter int TMO_TICKS = 12
) (
  input  logic             clk,
  input  logic             rst,
  output logic             alloc_valid_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             alloc_ready_i,
  input  logic             cpl_v_i,
  input  logic [TAG_W-1:0] cpl_tag_i,
  input  logic             cpl_last_i,
  output logic             ucpl_v_o,
  output logic [TAG_W-1:0] ucpl_tag_o,
  output logic             tmo_v_o,
  output logic [TAG_W-1:0] tmo_tag_o,
  output logic [TAG_W:0]   outstanding_o
);

  localparam int               PRE_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYC - 1);
  localparam logic [3:0]       TMO_AGE = 4'(TMO_TICKS);
  localparam int               CNT_W   = TAG_W + 1;

  logic [NUM_TAGS-1:0] busy;
  logic [3:0]          age [NUM_TAGS];
  logic [PRE_W-1:0]    presc;

  logic                tick;
  logic                alloc_fire;
  logic [NUM_TAGS-1:0] cpl_hit;
  logic                cpl_ok;
  logic                tmo_any;
  logic [TAG_W-1:0]    tmo_sel;

  assign tick          = (presc == PRE_MAX);
  assign alloc_valid_o = ~rst & ~&busy;
  assign alloc_fire    = alloc_valid_o & alloc_ready_i;
  assign cpl_ok        = |cpl_hit;

  // Priority-encode the lowest free tag; reads 0 when the pool is full.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave it unassigned and infer a latch.
    alloc_tag_o = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_tag_o = TAG_W'(i);
    end
  end

  // One-hot match of the incoming completion against outstanding tags;
  // out-of-range tags simply match nothing.
  always_comb begin
    cpl_hit = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      cpl_hit[i] = cpl_v_i && busy[i] && (cpl_tag_i == TAG_W'(i));
    end
  end

  // Pick the lowest expired tag, skipping one that is being completed now.
  always_comb begin
    tmo_any = 1'b0;
    tmo_sel = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (busy[i] && (age[i] == TMO_AGE) && !cpl_hit[i]) begin
        tmo_any = 1'b1;
        tmo_sel = TAG_W'(i);
      end
    end
  end

  // Tag state, prescaler, report pulses and outstanding count.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      presc         <= '0;
      ucpl_v_o      <= 1'b0;
      ucpl_tag_o    <= '0;
      tmo_v_o       <= 1'b0;
      tmo_tag_o     <= '0;
      outstanding_o <= '0;
      // NOTE: the age array is cleared too; it is small flop storage, and a
      // defined value keeps every tag's state consistent straight out of reset.
      for (int i = 0; i < NUM_TAGS; i++) age[i] <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every term on the
      // right-hand side sees the value from the start of the cycle.
      presc <= tick ? '0 : presc + 1'b1;

      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_fire && (alloc_tag_o == TAG_W'(i))) begin
          busy[i] <= 1'b1;
          age[i]  <= '0;
        end else if (cpl_hit[i]) begin
          if (cpl_last_i) busy[i] <= 1'b0;
          else            age[i]  <= '0;
        end else begin
          if (tmo_any && (tmo_sel == TAG_W'(i))) busy[i] <= 1'b0;
          if (tick && busy[i] && (age[i] < TMO_AGE)) age[i] <= age[i] + 4'd1;
        end
      end

      ucpl_v_o <= cpl_v_i && !cpl_ok;
      if (cpl_v_i && !cpl_ok) ucpl_tag_o <= cpl_tag_i;

      tmo_v_o <= tmo_any;
      if (tmo_any) tmo_tag_o <= tmo_sel;

      outstanding_o <= outstanding_o + CNT_W'(alloc_fire)
                       - CNT_W'(cpl_ok & cpl_last_i) - CNT_W'(tmo_any);
    end
  end

endmodule

// File: tb/tb_tl_np_tag_mgr.sv
// Bench for tl_np_tag_mgr: directed scenarios then random traffic, all
// outputs compared every cycle against a tag-pool reference model.
module tb_tl_np_tag_mgr;

  localparam int NT   = 32;
  localparam int TW   = 8;
  localparam int TICK = 16;
  localparam int TMO  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid_o;
  logic [TW-1:0] alloc_tag_o;
  logic          alloc_ready_i;
  logic          cpl_v_i;
  logic [TW-1:0] cpl_tag_i;
  logic          cpl_last_i;
  logic          ucpl_v_o;
  logic [TW-1:0] ucpl_tag_o;
  logic          tmo_v_o;
  logic [TW-1:0] tmo_tag_o;
  logic [TW:0]   outstanding_o;

  always #5 clk = ~clk;

  tl_np_tag_mgr #(
    .NUM_TAGS (NT),
    .TAG_W    (TW),
    .TICK_CYC (TICK),
    .TMO_TICKS(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid_o(alloc_valid_o),
    .alloc_tag_o  (alloc_tag_o),
    .alloc_ready_i(alloc_ready_i),
    .cpl_v_i      (cpl_v_i),
    .cpl_tag_i    (cpl_tag_i),
    .cpl_last_i   (cpl_last_i),
    .ucpl_v_o     (ucpl_v_o),
    .ucpl_tag_o   (ucpl_tag_o),
    .tmo_v_o      (tmo_v_o),
    .tmo_tag_o    (tmo_tag_o),
    .outstanding_o(outstanding_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: which tags are out, and how many ticks each has seen
  // since it was issued or last refreshed.
  bit m_busy  [NT];
  int m_ticks [NT];
  int m_phase;
  bit e_ucpl_v;
  int e_ucpl_tag;
  bit e_tmo_v;
  int e_tmo_tag;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NT; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_step(input bit r, input bit ar, input bit cv, input int ct, input bit cl);
    int  lf;
    bit  fire;
    bit  ok;
    int  tsel;
    if (r) begin
      for (int i = 0; i < NT; i++) begin
        m_busy[i]  = 1'b0;
        m_ticks[i] = 0;
      end
      m_phase  = 0;
      e_ucpl_v = 1'b0;
      e_tmo_v  = 1'b0;
      return;
    end
    lf   = lowest_free();
    fire = ar && (lf >= 0);
    ok   = 1'b0;
    if (cv && ct < NT) ok = m_busy[ct];
    tsel = -1;
    for (int i = 0; i < NT; i++)
      if (tsel < 0 && m_busy[i] && m_ticks[i] >= TMO && !(ok && ct == i)) tsel = i;
    if (m_phase == TICK - 1)
      for (int i = 0; i < NT; i++) if (m_busy[i]) m_ticks[i]++;
    if (fire) begin
      m_busy[lf]  = 1'b1;
      m_ticks[lf] = 0;
    end
    if (ok) begin
      if (cl) m_busy[ct]  = 1'b0;
      else    m_ticks[ct] = 0;
    end
    if (tsel >= 0) m_busy[tsel] = 1'b0;
    m_phase  = (m_phase + 1) % TICK;
    e_ucpl_v = cv && !ok;
    if (e_ucpl_v) e_ucpl_tag = ct;
    e_tmo_v = (tsel >= 0);
    if (e_tmo_v) e_tmo_tag = tsel;
  endtask

  task automatic compare_all();
    int lf;
    lf = lowest_free();
    check("alloc_valid", alloc_valid_o, (!rst && lf >= 0) ? 1 : 0);
    check("alloc_tag", alloc_tag_o, (lf < 0) ? 0 : lf);
    check("outstanding", outstanding_o, busy_count());
    check("ucpl_v", ucpl_v_o, e_ucpl_v);
    if (e_ucpl_v) check("ucpl_tag", ucpl_tag_o, e_ucpl_tag);
    check("tmo_v", tmo_v_o, e_tmo_v);
    if (e_tmo_v) check("tmo_tag", tmo_tag_o, e_tmo_tag);
  endtask

  // Drive one cycle of inputs, advance the model across the same edge,
  // then compare on the falling edge.
  task automatic step(input bit r, input bit ar, input bit cv, input int ct, input bit cl);
    rst           = r;
    alloc_ready_i = ar;
    cpl_v_i       = cv;
    cpl_tag_i     = TW'(ct);
    cpl_last_i    = cl;
    model_step(r, ar, cv, ct, cl);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic go(input bit ar, input bit cv, input int ct, input bit cl);
    step(1'b0, ar, cv, ct, cl);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0_cyc, t1_cyc, n_tmo, t0_tag, t1_tag, cnt0, cnt1;
    bit found;

    // Scenario 1: four back-to-back allocations out of reset.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) go(1'b1, 1'b0, 0, 1'b0);
    check("p1_outstanding", outstanding_o, 4);

    // Scenario 2: fill the pool, then free tag 5 and see it re-offered.
    for (int k = 0; k < 28; k++) go(1'b1, 1'b0, 0, 1'b0);
    check("p2_full_valid", alloc_valid_o, 0);
    check("p2_full_tag", alloc_tag_o, 0);
    go(1'b0, 1'b1, 5, 1'b1);
    check("p2_reoffer_valid", alloc_valid_o, 1);
    check("p2_reoffer_tag", alloc_tag_o, 5);

    // Scenario 3: unexpected completions (free tag, out of range, tag being
    // allocated in the same cycle).
    go(1'b0, 1'b1, 9, 1'b1);
    go(1'b0, 1'b1, 9, 1'b1);
    check("p3_free_ucpl_v", ucpl_v_o, 1);
    check("p3_free_ucpl_tag", ucpl_tag_o, 9);
    check("p3_outstanding", outstanding_o, 30);
    go(1'b0, 1'b1, 40, 1'b0);
    check("p3_range_ucpl_tag", ucpl_tag_o, 40);
    go(1'b1, 1'b1, 5, 1'b1);
    check("p3_same_cycle_ucpl", ucpl_v_o, 1);
    check("p3_same_cycle_out", outstanding_o, 31);

    // Scenario 4: two idle tags time out on consecutive cycles.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    go(1'b1, 1'b0, 0, 1'b0);
    go(1'b1, 1'b0, 0, 1'b0);
    n_tmo = 0; t0_cyc = 0; t1_cyc = 0; t0_tag = 99; t1_tag = 99;
    for (int k = 0; k < 120 && n_tmo < 2; k++) begin
      go(1'b0, 1'b0, 0, 1'b0);
      if (tmo_v_o === 1'b1) begin
        if (n_tmo == 0) begin t0_cyc = cyc; t0_tag = int'(tmo_tag_o); end
        else            begin t1_cyc = cyc; t1_tag = int'(tmo_tag_o); end
        n_tmo++;
      end
    end
    check("p4_tmo_count", n_tmo, 2);
    check("p4_first_tag", t0_tag, 0);
    check("p4_second_tag", t1_tag, 1);
    check("p4_consecutive", t1_cyc - t0_cyc, 1);
    go(1'b0, 1'b0, 0, 1'b0);
    check("p4_empty", outstanding_o, 0);

    // Scenario 5: periodic refresh keeps tag 0 alive while tag 1 times out.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    go(1'b1, 1'b0, 0, 1'b0);
    go(1'b1, 1'b0, 0, 1'b0);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 100; k++) begin
      if (k % 6 == 5) go(1'b0, 1'b1, 0, 1'b0);
      else            go(1'b0, 1'b0, 0, 1'b0);
      if (tmo_v_o === 1'b1 && tmo_tag_o == 0) cnt0++;
      if (tmo_v_o === 1'b1 && tmo_tag_o == 1) cnt1++;
    end
    check("p5_tag0_tmo", cnt0, 0);
    check("p5_tag1_tmo", cnt1, 1);

    // Scenario 6: completion beats timeout on the same tag; reset drops all.
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) go(1'b1, 1'b0, 0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (m_busy[0] && m_ticks[0] >= TMO) begin
        found = 1'b1;
        break;
      end
      go(1'b0, 1'b0, 0, 1'b0);
    end
    check("p6_expiry_reached", found, 1);
    go(1'b0, 1'b1, 0, 1'b1);
    check("p6_tmo_v", tmo_v_o, 1);
    check("p6_tmo_moves_on", tmo_tag_o, 1);
    check("p6_outstanding", outstanding_o, 2);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 10; k++) go(1'b1, 1'b0, 0, 1'b0);
    check("p6_ten_busy", outstanding_o, 10);
    step(1'b1, 1'b1, 1'b1, 3, 1'b1);
    check("p6_rst_out", outstanding_o, 0);
    check("p6_rst_valid", alloc_valid_o, 0);
    check("p6_rst_ucpl", ucpl_v_o, 0);
    check("p6_rst_tmo", tmo_v_o, 0);
    go(1'b0, 1'b0, 0, 1'b0);
    check("p6_after_rst_tag", alloc_tag_o, 0);
    check("p6_after_rst_valid", alloc_valid_o, 1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      bit r, ar, cv, cl;
      int ct;
      r  = ($urandom_range(0, 399) == 0);
      ar = ($urandom_range(0, 9) < 6);
      cv = ($urandom_range(0, 9) < 5);
      cl = ($urandom_range(0, 9) < 7);
      ct = ($urandom_range(0, 9) == 0) ? $urandom_range(NT, NT + 15)
                                       : $urandom_range(0, NT - 1);
      step(r, ar, cv, ct, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
